// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, parameter
// defaults and the counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int DEF_PLL_RESET_CYCLES = 16;
    localparam int DEF_STABLE_CYCLES    = 1024;
    localparam int DEF_TIMEOUT_CYCLES   = 65536;
    localparam int DEF_MAX_RETRIES      = 7;
    localparam int RETRY_W              = 3;

    // Wide enough to hold (largest cycle count - 1); never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on reset.
module sync2 (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a qualified lock and releases downstream reset,
// retrying on timeout and latching a sticky failure after MAX_RETRIES retries.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RESET_CYCLES = DEF_PLL_RESET_CYCLES,
    parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    output logic               pll_resetb,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W = cnt_width(PLL_RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 sys_reset_q, sys_reset_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;
    logic                 locked_s;

    sync2 u_sync2 (
        .clock_i (clock),
        .reset_i (reset),
        .d_i     (locked),
        .q_o     (locked_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    // Every terminal compare fires before cnt can overflow, so cnt never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = HOLD;
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they register on the same edge as it.
    always_comb begin
        pll_resetb_d = !((state_d == HOLD) || (state_d == FAIL));
        sys_reset_d  = (state_d != RUN);
        ready_d      = (state_d == RUN);
        fail_d       = (state_d == FAIL);
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

    a_ready_releases: assert property (@(posedge clock) disable iff (reset)
        ready |-> !sys_reset);
    a_fail_holds_pll: assert property (@(posedge clock) disable iff (reset)
        fail |-> !pll_resetb);
    a_retry_bounded: assert property (@(posedge clock) disable iff (reset)
        retry_count <= RETRY_MAX);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a phase/elapsed-time model predicts
// the outputs after every edge, and a monitor compares them mid-cycle.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int SC  = 8;
    localparam int TO  = 32;
    localparam int MR  = 2;

    localparam int PH_HOLD   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [2:0] retry_count;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES (PRC),
        .STABLE_CYCLES    (SC),
        .TIMEOUT_CYCLES   (TO),
        .MAX_RETRIES      (MR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .pll_resetb  (pll_resetb),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 clock = ~clock;

    int         phase;
    int         elapsed;
    int         retries;
    bit         seenLock [2];
    logic [6:0] expQ [$];
    int         checks = 0;
    int         errors = 0;
    int         cycleNo = 0;
    event       asyncEv;

    task automatic modelReset();
        phase       = PH_HOLD;
        elapsed     = 0;
        retries     = 0;
        seenLock[0] = 1'b0;
        seenLock[1] = 1'b0;
    endtask

    function automatic logic [6:0] expectedOutputs();
        logic pr, sr, rd, fl;
        pr = !(phase == PH_HOLD || phase == PH_FAIL);
        sr = (phase != PH_RUN);
        rd = (phase == PH_RUN);
        fl = (phase == PH_FAIL);
        return {pr, sr, rd, fl, 3'(retries)};
    endfunction

    // The lock level the sequencer acts on is the one sampled two edges ago.
    task automatic modelStep(input bit lockIn);
        bit lockSeen;
        lockSeen    = seenLock[1];
        seenLock[1] = seenLock[0];
        seenLock[0] = lockIn;
        if (phase == PH_HOLD) begin
            elapsed++;
            if (elapsed == PRC) begin
                phase = PH_WAIT;
                elapsed = 0;
            end
        end else if (phase == PH_WAIT) begin
            if (lockSeen) begin
                phase = PH_STABLE;
                elapsed = 0;
            end else begin
                elapsed++;
                if (elapsed == TO) begin
                    elapsed = 0;
                    if (retries < MR) begin
                        retries++;
                        phase = PH_HOLD;
                    end else begin
                        phase = PH_FAIL;
                    end
                end
            end
        end else if (phase == PH_STABLE) begin
            if (!lockSeen) begin
                phase = PH_WAIT;
                elapsed = 0;
            end else begin
                elapsed++;
                if (elapsed == SC) begin
                    phase = PH_RUN;
                    retries = 0;
                end
            end
        end else if (phase == PH_RUN) begin
            if (!lockSeen) begin
                phase = PH_HOLD;
                elapsed = 0;
            end
        end
    endtask

    task automatic runCycle();
        @(posedge clock);
        cycleNo++;
        if (reset) modelReset();
        else modelStep(locked);
        expQ.push_back(expectedOutputs());
    endtask

    task automatic applyStimulus(input bit lockVal, input int n);
        #1 locked = lockVal;
        repeat (n) runCycle();
    endtask

    // Reset is raised mid-cycle so the outputs are checked before any edge.
    task automatic pulseReset();
        @(negedge clock);
        #1 reset = 1'b1;
        #1 modelReset();
        expQ.push_back(expectedOutputs());
        -> asyncEv;
        repeat (2) runCycle();
        #1 reset = 1'b0;
    endtask

    task automatic checkOutput(input logic [6:0] exp);
        logic [6:0] got;
        got = {pll_resetb, sys_reset, ready, fail, retry_count};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL outputs cycle %0d: got pll_resetb=%b sys_reset=%b ready=%b fail=%b retry_count=%0d, expected pll_resetb=%b sys_reset=%b ready=%b fail=%b retry_count=%0d",
                     cycleNo, got[6], got[5], got[4], got[3], got[2:0],
                     exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock or asyncEv);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        modelReset();
        pulseReset();

        applyStimulus(1'b0, 9);
        applyStimulus(1'b1, 25);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 20);

        pulseReset();
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 20);

        pulseReset();
        applyStimulus(1'b1, 8);
        pulseReset();
        applyStimulus(1'b0, 120);
        applyStimulus(1'b1, 20);
        pulseReset();
        applyStimulus(1'b1, 25);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) pulseReset();
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end

        @(negedge clock);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
